egress_scheduler: RTL and testbench

// - Packet-aware round-robin scheduler and mux for one egress port of the 4-port switch.
// - NUM_PORTS ingress queues offer valid/ready packet streams.
// - Grants one queue at a time and holds the grant from SOP to EOP, so packets never interleave.
// - Enforces a maximum packet length. Sits between the ingress FIFOs and the egress port logic.

---
 rtl/switch_pkg.sv | 14 +
 rtl/rr_pick.sv | 43 ++++
 rtl/egress_scheduler.sv | 144 ++++++++++++++
 tb/tb_egress_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: default sizing and the egress scheduler state type.
package switch_pkg;

   localparam int unsigned NUM_PORTS_DEF   = 4;
   localparam int unsigned DATA_W_DEF      = 8;
   localparam int unsigned MAX_PKT_LEN_DEF = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the offset back.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         onehot_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 found_o
);

   localparam int unsigned IdxW = $clog2(N);
   localparam logic [IdxW:0] NumReq = (IdxW + 1)'(N);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [IdxW-1:0] offset;
   logic [IdxW:0]  idx_sum;

   assign req_dbl = {req_i, req_i};

   // Rotate, encode lowest set bit, map offset back to an absolute index.
   always_comb begin
      req_rot  = N'(req_dbl >> ptr_i);
      found_o  = 1'b0;
      offset   = '0;
      // Descending scan so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            found_o = 1'b1;
            offset  = IdxW'(i);
         end
      end
      idx_sum = {1'b0, ptr_i} + {1'b0, offset};
      if (idx_sum >= NumReq) begin
         idx_sum = idx_sum - NumReq;
      end
      idx_o    = idx_sum[IdxW-1:0];
      onehot_o = found_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/egress_scheduler.sv
// Packet-aware round-robin scheduler and mux for one egress port. A grant is
// taken on SOP and held through EOP; over-length packets are cut and drained.
module egress_scheduler
   import switch_pkg::*;
#(
   parameter int unsigned NUM_PORTS   = NUM_PORTS_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned MAX_PKT_LEN = MAX_PKT_LEN_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          in_valid_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
   input  logic [NUM_PORTS-1:0]          in_sop_i,
   input  logic [NUM_PORTS-1:0]          in_eop_i,
   output logic [NUM_PORTS-1:0]          in_ready_o,
   output logic                          out_valid_o,
   output logic [DATA_W-1:0]             out_data_o,
   output logic                          out_sop_o,
   output logic                          out_eop_o,
   input  logic                          out_ready_i,
   output logic [$clog2(NUM_PORTS)-1:0]  out_src_o,
   output logic                          busy_o,
   output logic                          err_len_o
);

   localparam int unsigned SrcW = $clog2(NUM_PORTS);
   localparam int unsigned CntW = $clog2(MAX_PKT_LEN + 1);
   localparam logic [CntW-1:0] LastCnt  = CntW'(MAX_PKT_LEN - 1);
   localparam logic [SrcW-1:0] LastPort = SrcW'(NUM_PORTS - 1);

   sched_state_e    state_q, state_d;
   logic [SrcW-1:0] ptr_q, ptr_d;
   logic [SrcW-1:0] out_src_q, out_src_d;
   logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
   logic            err_len_q, err_len_d;

   logic [NUM_PORTS-1:0] pick_onehot;
   logic [SrcW-1:0]      pick_idx;
   logic                 pick_found;
   logic                 unused_pick_onehot;

   logic [DATA_W-1:0] data_arr [NUM_PORTS];
   logic              g_valid;
   logic              g_sop;
   logic              g_eop;
   logic              g_last;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign data_arr[p] = in_data_i[p*DATA_W +: DATA_W];
   end

   // Only valid SOP beats compete for the egress.
   rr_pick #(
      .N (NUM_PORTS)
   ) u_rr_pick (
      .req_i    (in_valid_i & in_sop_i),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .found_o  (pick_found)
   );

   assign unused_pick_onehot = ^pick_onehot;

   assign g_valid = in_valid_i[out_src_q];
   assign g_sop   = in_sop_i[out_src_q];
   assign g_eop   = in_eop_i[out_src_q];
   // The beat at this count is the last one allowed through.
   assign g_last  = (beat_cnt_q == LastCnt);

   // Next-state, grant bookkeeping and egress mux.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_src_d   = out_src_q;
      beat_cnt_d  = beat_cnt_q;
      err_len_d   = 1'b0;
      in_ready_o  = '0;
      out_valid_o = 1'b0;
      out_data_o  = '0;
      out_sop_o   = 1'b0;
      out_eop_o   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               out_src_d  = pick_idx;
               ptr_d      = (pick_idx == LastPort) ? '0 : pick_idx + 1'b1;
               beat_cnt_d = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            out_valid_o           = g_valid;
            out_data_o            = data_arr[out_src_q];
            out_sop_o             = g_sop;
            out_eop_o             = g_eop | g_last;
            in_ready_o[out_src_q] = out_ready_i;
            if (g_valid && out_ready_i) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (g_eop) begin
                  state_d = IDLE;
               end else if (g_last) begin
                  err_len_d = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Swallow the rest of the cut packet so the source can move on.
            in_ready_o[out_src_q] = 1'b1;
            if (g_valid && g_eop) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and grant registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         out_src_q  <= '0;
         beat_cnt_q <= '0;
         err_len_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         out_src_q  <= out_src_d;
         beat_cnt_q <= beat_cnt_d;
         err_len_q  <= err_len_d;
      end
   end

   assign out_src_o = out_src_q;
   assign busy_o    = (state_q != IDLE);
   assign err_len_o = err_len_q;

endmodule

// File: tb/tb_egress_scheduler.sv
// Bench for egress_scheduler: directed scenarios plus random traffic, checked
// against a packet-level reference model and a per-port data scoreboard.
module tb_egress_scheduler;

   localparam int NP   = 4;
   localparam int DW   = 8;
   localparam int MAXL = 4;
   localparam int SW   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NP-1:0]    in_valid;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]    in_sop;
   logic [NP-1:0]    in_eop;
   logic [NP-1:0]    in_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic             out_sop;
   logic             out_eop;
   logic             out_ready;
   logic [SW-1:0]    out_src;
   logic             busy;
   logic             err_len;

   always #5 clk = ~clk;

   egress_scheduler #(
      .NUM_PORTS   (NP),
      .DATA_W      (DW),
      .MAX_PKT_LEN (MAXL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_sop_i    (in_sop),
      .in_eop_i    (in_eop),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_sop_o   (out_sop),
      .out_eop_o   (out_eop),
      .out_ready_i (out_ready),
      .out_src_o   (out_src),
      .busy_o      (busy),
      .err_len_o   (err_len)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Source queues hold {sop, eop, data}; exp_q holds the data that must egress.
   logic [9:0]    src_q [NP][$];
   logic [DW-1:0] exp_q [NP][$];
   bit [NP-1:0]   offer = '0;
   bit            gaps  = 1'b0;

   // Reference: mode 0 = waiting for a packet, 1 = forwarding, 2 = discarding.
   int m_mode = 0, m_owner = 0, m_next = 0, m_sent = 0;
   bit m_err = 1'b0;

   int cyc = 0, last_hs = 0, obs_beats = 0, obs_err = 0;
   int grants[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pending();
      for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic add_pkt(input int p, input int len);
      for (int b = 0; b < len; b++) begin
         logic [DW-1:0] d;
         d = DW'($urandom);
         src_q[p].push_back({(b == 0), (b == len - 1), d});
         if (b < MAXL) exp_q[p].push_back(d);
      end
   endtask

   task automatic drive_inputs();
      for (int p = 0; p < NP; p++) begin
         logic [9:0] b;
         b = (src_q[p].size() > 0) ? src_q[p][0] : 10'h0;
         in_valid[p]          = offer[p];
         in_sop[p]            = b[9];
         in_eop[p]            = b[8];
         in_data[p*DW +: DW]  = b[7:0];
      end
   endtask

   task automatic refresh_offers();
      for (int p = 0; p < NP; p++)
         if (!offer[p] && src_q[p].size() > 0 && (!gaps || $urandom_range(3, 0) != 0))
            offer[p] = 1'b1;
   endtask

   task automatic cycle();
      logic [NP-1:0] e_ready;
      logic          e_valid, e_sop, e_eop;
      logic [DW-1:0] e_data;
      int g, s, n_mode, n_owner, n_next, n_sent;
      bit n_err, found;
      refresh_offers();
      drive_inputs();
      @(negedge clk);
      g = m_owner;
      e_ready = '0; e_valid = 1'b0; e_data = '0; e_sop = 1'b0; e_eop = 1'b0;
      if (m_mode == 1) begin
         e_valid    = in_valid[g];
         e_data     = in_data[g*DW +: DW];
         e_sop      = in_sop[g];
         e_eop      = in_eop[g] || (m_sent == MAXL - 1);
         e_ready[g] = out_ready;
      end else if (m_mode == 2) begin
         e_ready[g] = 1'b1;
      end
      chk("in_ready", in_ready, e_ready);
      chk("out_valid", out_valid, e_valid);
      chk("busy", busy, m_mode != 0);
      chk("out_src", out_src, m_owner);
      chk("err_len", err_len, m_err);
      if (m_mode != 2) begin
         chk("out_data", out_data, e_data);
         chk("out_sop", out_sop, e_sop);
         chk("out_eop", out_eop, e_eop);
      end
      if (err_len) obs_err++;
      if (out_valid && out_ready) begin
         s = int'(out_src);
         obs_beats++;
         last_hs = cyc;
         if (out_sop) grants.push_back(s);
         chk("egress_beat_expected", exp_q[s].size() > 0, 1);
         if (exp_q[s].size() > 0) chk("egress_data_order", out_data, exp_q[s].pop_front());
      end
      n_mode = m_mode; n_owner = m_owner; n_next = m_next; n_sent = m_sent; n_err = 1'b0;
      if (m_mode == 0) begin
         found = 1'b0;
         for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_next + k) % NP;
            if (!found && in_valid[p] && in_sop[p]) begin
               found = 1'b1; n_owner = p; n_next = (p + 1) % NP; n_sent = 0; n_mode = 1;
            end
         end
      end else if (m_mode == 1) begin
         if (in_valid[g] && out_ready) begin
            n_sent = m_sent + 1;
            if (in_eop[g]) n_mode = 0;
            else if (n_sent == MAXL) begin
               n_mode = 2; n_err = 1'b1;
            end
         end
      end else begin
         if (in_valid[g] && in_eop[g]) n_mode = 0;
      end
      for (int p = 0; p < NP; p++)
         if (offer[p] && e_ready[p]) begin
            void'(src_q[p].pop_front());
            offer[p] = 1'b0;
         end
      @(posedge clk);
      #1;
      m_mode = n_mode; m_owner = n_owner; m_next = n_next; m_sent = n_sent; m_err = n_err;
      cyc++;
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((pending() || m_mode != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_drained_in_budget"}, pending() || m_mode != 0, 0);
   endtask

   int t0, b0, e0;
   int exp_g[$];

   initial begin
      rst_n = 1'b0; out_ready = 1'b1;
      in_valid = '1; in_sop = '1; in_eop = '0; in_data = '1;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sop", out_sop, 0);
      chk("rst_out_eop", out_eop, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_err_len", err_len, 0);
      in_valid = '0; in_sop = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // All four ports start a 2-beat packet together.
      for (int p = 0; p < NP; p++) add_pkt(p, 2);
      grants.delete(); t0 = cyc; b0 = obs_beats;
      run_idle("t1", 60);
      chk("t1_beats", obs_beats - b0, 8);
      chk("t1_last_beat_cycle", last_hs - t0, 11);
      exp_g = '{0, 1, 2, 3};
      chk("t1_grant_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("t1_grant_order", grants[i], exp_g[i]);

      // Port 1 raises SOP while port 2 is mid-packet; then ptr must sit at 2.
      add_pkt(2, 4);
      grants.delete();
      cycle(); cycle();
      add_pkt(1, 2);
      run_idle("t2a", 40);
      add_pkt(1, 1); add_pkt(2, 1);
      run_idle("t2b", 40);
      exp_g = '{2, 1, 2, 1};
      chk("t2_grant_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("t2_grant_order", grants[i], exp_g[i]);

      // Egress ready toggles during a 4-beat packet.
      add_pkt(0, 4);
      b0 = obs_beats;
      for (int n = 0; n < 40 && (pending() || m_mode != 0); n++) begin
         out_ready = (n % 2 == 0);
         cycle();
      end
      out_ready = 1'b1;
      chk("t3_handshakes", obs_beats - b0, 4);
      chk("t3_drained", pending() || m_mode != 0, 0);

      // Over-length packet: 7 beats against a 4-beat limit.
      add_pkt(3, 7);
      b0 = obs_beats; e0 = obs_err;
      run_idle("t4", 40);
      chk("t4_beats", obs_beats - b0, 4);
      chk("t4_err_pulses", obs_err - e0, 1);
      chk("t4_scoreboard_empty", exp_q[3].size(), 0);

      // Back-to-back single-beat packets from port 0.
      for (int i = 0; i < 6; i++) add_pkt(0, 1);
      grants.delete(); t0 = cyc;
      run_idle("t5", 40);
      chk("t5_last_beat_cycle", last_hs - t0, 11);
      chk("t5_grant_count", grants.size(), 6);
      for (int i = 0; i < grants.size(); i++) chk("t5_grant_port", grants[i], 0);

      // Reset asserted at beat 2 of a 4-beat packet from port 2.
      add_pkt(2, 4);
      cycle(); cycle();
      refresh_offers();
      drive_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_in_ready", in_ready, 0);
      chk("t6_out_valid", out_valid, 0);
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
      end
      offer = '0;
      m_mode = 0; m_owner = 0; m_next = 0; m_sent = 0; m_err = 1'b0;
      drive_inputs();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t6_out_src", out_src, 0);
      add_pkt(1, 1); add_pkt(3, 1);
      grants.delete();
      run_idle("t6", 20);
      exp_g = '{1, 3};
      chk("t6_grant_count", grants.size(), 2);
      for (int i = 0; i < 2 && i < grants.size(); i++) chk("t6_grant_order", grants[i], exp_g[i]);

      // Random traffic with source gaps and egress backpressure.
      gaps = 1'b1;
      for (int n = 0; n < 600; n++) begin
         int p;
         out_ready = ($urandom_range(3, 0) != 0);
         p = $urandom_range(NP - 1, 0);
         if ($urandom_range(5, 0) == 0 && src_q[p].size() < 16) add_pkt(p, $urandom_range(7, 1));
         cycle();
      end
      out_ready = 1'b1;
      gaps = 1'b0;
      run_idle("t7", 600);
      for (int p = 0; p < NP; p++) chk("t7_scoreboard_empty", exp_q[p].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
